// File: rtl/iob_eth_pkg.sv
// iob_eth_pkg: shared Ethernet MII constants, CRC-32 constants and helpers,
// and the state encoding of the MII RX checker FSM.
package iob_eth_pkg;

    localparam logic [3:0]  MII_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  MII_SFD_NIB      = 4'hD;

    localparam logic [31:0] CRC32_POLY       = 32'h04C11DB7;
    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;
    // Residue in normal (MSB-first) bit order; the reflected engine holds its mirror image.
    localparam logic [31:0] CRC32_RESIDUE    = 32'hC704DD7B;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_END  = 3'd3,
        ST_DROP = 3'd4
    } mii_rx_state_t;

    function automatic logic [31:0] bit_reverse32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = x[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/iob_eth_crc32_nib.sv
// iob_eth_crc32_nib: reflected CRC-32 engine consuming one MII nibble per
// enabled clock, bit 0 first. crc_next_o is the register value after the
// current nibble, so callers can judge a byte in the cycle it completes.
module iob_eth_crc32_nib
    import iob_eth_pkg::*;
(
    input  logic        clk_i,
    input  logic        cke_i,
    input  logic        rst_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [3:0]  d_i,
    output logic [31:0] crc_next_o
);

    logic [31:0] r_crc;

    // Four serial LFSR steps of the reflected polynomial.
    always_comb begin
        crc_next_o = r_crc ^ {28'h0, d_i};
        for (int i = 0; i < 4; i++) begin
            crc_next_o = crc_next_o[0] ? ((crc_next_o >> 1) ^ CRC32_POLY_REFL) : (crc_next_o >> 1);
        end
    end

    // CRC register: clear has priority over accumulate.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_crc <= CRC32_INIT;
        end else if (cke_i) begin
            if (clr_i) begin
                r_crc <= CRC32_INIT;
            end else if (en_i) begin
                r_crc <= crc_next_o;
            end
        end
    end

endmodule

// File: rtl/iob_eth_mii_rx_chk.sv
// iob_eth_mii_rx_chk: PHY-side receiver/checker for the MAC MII TX interface.
// Strips preamble/SFD, packs nibbles into bytes, checks CRC-32 and reports one
// status word per frame.
// Build option IOB_ETH_MII_CHK_STRIP_FCS_EN: hold 5 bytes so the FCS is not
// streamed; otherwise hold 1 byte and stream every byte including the FCS.
//
// state | meaning
// IDLE  | waiting for MTxEn
// PRE   | counting 0x5 preamble nibbles, waiting for SFD 0xD
// DATA  | packing nibbles into bytes, updating CRC and length
// END   | one cycle: status pulse, last held byte emitted; decodes a new frame start like IDLE
// DROP  | bad preamble; absorb the frame until MTxEn falls, then report via END
module iob_eth_mii_rx_chk
    import iob_eth_pkg::*;
#(
    parameter int MIN_PRE_NIBBLES = 15,
    parameter int LEN_W           = 11,
    parameter int MIN_FRAME_LEN   = 64,
    parameter int MAX_FRAME_LEN   = 1518
) (
    input  logic             clk_i,
    input  logic             cke_i,
    input  logic             rst_i,
    input  logic             mii_tx_en_i,
    input  logic [3:0]       mii_tx_d_i,
    input  logic             mii_tx_er_i,
    output logic             m_valid_o,
    output logic [7:0]       m_data_o,
    output logic             m_last_o,
    output logic             stat_valid_o,
    output logic [LEN_W-1:0] stat_len_o,
    output logic             stat_crc_err_o,
    output logic             stat_align_err_o,
    output logic             stat_len_err_o,
    output logic             stat_phy_err_o,
    output logic             stat_pre_err_o
);

`ifdef IOB_ETH_MII_CHK_STRIP_FCS_EN
    localparam int HOLD_D = 5;
`else
    localparam int HOLD_D = 1;
`endif
    localparam int HCNT_W = $clog2(HOLD_D + 1);
    localparam int PCNT_W = $clog2(MIN_PRE_NIBBLES + 1);
    localparam logic [HCNT_W-1:0] HOLD_FULL = HCNT_W'(HOLD_D);
    localparam logic [PCNT_W-1:0] PRE_MIN   = PCNT_W'(MIN_PRE_NIBBLES);
    localparam logic [LEN_W-1:0]  LEN_MIN   = LEN_W'(MIN_FRAME_LEN);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(MAX_FRAME_LEN);

    mii_rx_state_t     r_state;
    mii_rx_state_t     w_state_nxt;
    logic [PCNT_W-1:0] r_pre_cnt;
    logic [3:0]        r_nib_lo;
    logic              r_odd;
    logic              r_crc_ok;
    logic              r_phy_err;
    logic              r_pre_err;
    logic [LEN_W-1:0]  r_len;
    logic [7:0]        r_hold [HOLD_D];
    logic [HCNT_W-1:0] r_hcnt;
    logic              r_m_valid;
    logic [7:0]        r_m_data;

    logic [31:0]       w_crc_next;
    logic              w_idle_like;
    logic              w_data_nib;
    logic              w_to_drop;
    logic              w_good_end;
    logic              w_end_emit;
    logic [7:0]        w_byte;

    assign w_idle_like = (r_state == ST_IDLE) || (r_state == ST_END);
    assign w_data_nib  = (r_state == ST_DATA) && mii_tx_en_i;
    assign w_byte      = {mii_tx_d_i, r_nib_lo};
    assign w_to_drop   = (w_state_nxt == ST_DROP) && (r_state != ST_DROP);

    // The engine is held at its initial value outside DATA, so every frame starts clean.
    iob_eth_crc32_nib u_crc (
        .clk_i      (clk_i),
        .cke_i      (cke_i),
        .rst_i      (rst_i),
        .clr_i      (r_state != ST_DATA),
        .en_i       (w_data_nib),
        .d_i        (mii_tx_d_i),
        .crc_next_o (w_crc_next)
    );

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else if (cke_i) begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state decode; END reuses the IDLE decode so a zero-gap frame start is not lost.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_END: begin
                w_state_nxt = ST_IDLE;
                if (mii_tx_en_i) begin
                    w_state_nxt = (mii_tx_d_i == MII_PREAMBLE_NIB) ? ST_PRE : ST_DROP;
                end
            end
            ST_PRE: begin
                if (!mii_tx_en_i) begin
                    w_state_nxt = ST_IDLE;
                end else if (mii_tx_d_i == MII_PREAMBLE_NIB) begin
                    w_state_nxt = ST_PRE;
                end else if ((mii_tx_d_i == MII_SFD_NIB) && (r_pre_cnt >= PRE_MIN)) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!mii_tx_en_i) begin
                    w_state_nxt = ST_END;
                end
            end
            ST_DROP: begin
                if (!mii_tx_en_i) begin
                    w_state_nxt = ST_END;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: preamble count, nibble packing, length, CRC verdict, byte holding register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pre_cnt <= '0;
            r_nib_lo  <= '0;
            r_odd     <= 1'b0;
            r_crc_ok  <= 1'b0;
            r_phy_err <= 1'b0;
            r_pre_err <= 1'b0;
            r_len     <= '0;
            r_hcnt    <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            for (int i = 0; i < HOLD_D; i++) begin
                r_hold[i] <= '0;
            end
        end else if (cke_i) begin
            r_m_valid <= 1'b0;
            if (w_idle_like) begin
                r_pre_cnt <= PCNT_W'(1);
                r_odd     <= 1'b0;
                r_crc_ok  <= 1'b0;
                r_phy_err <= 1'b0;
                r_len     <= '0;
                r_hcnt    <= '0;
            end else if (r_state == ST_PRE) begin
                if ((mii_tx_d_i == MII_PREAMBLE_NIB) && (r_pre_cnt != PRE_MIN)) begin
                    r_pre_cnt <= r_pre_cnt + 1'b1;
                end
            end else if (w_data_nib) begin
                r_odd <= ~r_odd;
                if (mii_tx_er_i) begin
                    r_phy_err <= 1'b1;
                end
                if (!r_odd) begin
                    r_nib_lo <= mii_tx_d_i;
                end else begin
                    if (r_len != '1) begin
                        r_len <= r_len + 1'b1;
                    end
                    // Sampled only at byte boundaries, so a trailing odd nibble never affects it.
                    r_crc_ok <= (bit_reverse32(w_crc_next) == CRC32_RESIDUE);
                    for (int i = HOLD_D - 1; i > 0; i--) begin
                        r_hold[i] <= r_hold[i-1];
                    end
                    r_hold[0] <= w_byte;
                    if (r_hcnt == HOLD_FULL) begin
                        r_m_valid <= 1'b1;
                        r_m_data  <= r_hold[HOLD_D-1];
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
            end
            if (w_to_drop) begin
                r_pre_err <= 1'b1;
            end else if (w_idle_like) begin
                r_pre_err <= 1'b0;
            end
        end
    end

    // FSM outputs: status and the final held byte are presented during END.
    always_comb begin
        w_good_end       = (r_state == ST_END) && !r_pre_err;
        w_end_emit       = w_good_end && (r_hcnt == HOLD_FULL);
        m_valid_o        = r_m_valid || w_end_emit;
        m_data_o         = w_end_emit ? r_hold[HOLD_D-1] : r_m_data;
        m_last_o         = w_end_emit;
        stat_valid_o     = (r_state == ST_END);
        stat_pre_err_o   = (r_state == ST_END) && r_pre_err;
        stat_len_o       = w_good_end ? r_len : '0;
        stat_crc_err_o   = w_good_end && !r_crc_ok;
        stat_align_err_o = w_good_end && r_odd;
        stat_len_err_o   = w_good_end && ((r_len < LEN_MIN) || (r_len > LEN_MAX));
        stat_phy_err_o   = w_good_end && r_phy_err;
    end

endmodule

// File: tb/tb_iob_eth_mii_rx_chk.sv
// tb_iob_eth_mii_rx_chk: directed-frame bench for the MII RX checker.
`timescale 1ns/1ps
module tb_iob_eth_mii_rx_chk;

`ifdef IOB_ETH_MII_CHK_STRIP_FCS_EN
    localparam int D = 5;
`else
    localparam int D = 1;
`endif

    logic        clk = 1'b0;
    logic        cke;
    logic        rst;
    logic        en;
    logic [3:0]  d;
    logic        er;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        stat_valid;
    logic [10:0] stat_len;
    logic        crc_err, align_err, len_err, phy_err, pre_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] frm[$];
    logic [7:0] exp_b[$];
    logic [7:0] rx_b[$];
    int         rx_last[$];
    int         st_len[$];
    logic [4:0] st_flg[$];   // {crc, align, len, phy, pre}

    iob_eth_mii_rx_chk dut (
        .clk_i            (clk),
        .cke_i            (cke),
        .rst_i            (rst),
        .mii_tx_en_i      (en),
        .mii_tx_d_i       (d),
        .mii_tx_er_i      (er),
        .m_valid_o        (m_valid),
        .m_data_o         (m_data),
        .m_last_o         (m_last),
        .stat_valid_o     (stat_valid),
        .stat_len_o       (stat_len),
        .stat_crc_err_o   (crc_err),
        .stat_align_err_o (align_err),
        .stat_len_err_o   (len_err),
        .stat_phy_err_o   (phy_err),
        .stat_pre_err_o   (pre_err)
    );

    always #5 clk = ~clk;

    // Capture outputs half a cycle after the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            rx_b.push_back(m_data);
            if (m_last) rx_last.push_back(rx_b.size() - 1);
        end else if (m_last) begin
            rx_last.push_back(-1);
        end
        if (stat_valid) begin
            st_len.push_back(int'(stat_len));
            st_flg.push_back({crc_err, align_err, len_err, phy_err, pre_err});
        end
    end

    task automatic nib(input logic e, input logic [3:0] v, input logic x);
        @(negedge clk);
        en = e;
        d  = v;
        er = x;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) nib(1'b0, 4'h0, 1'b0);
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) nib(1'b1, 4'h5, 1'b0);
        nib(1'b1, 4'hD, 1'b0);
    endtask

    task automatic send_bytes(input int from, input int to, input int er_nib);
        logic [7:0] b;
        for (int i = from; i < to; i++) begin
            b = frm[i];
            nib(1'b1, b[3:0], (2*i) == er_nib);
            nib(1'b1, b[7:4], (2*i+1) == er_nib);
        end
    endtask

    // Payload of n-4 pattern bytes followed by FCS = ~CRC32, least significant byte first.
    task automatic build_frame(input int n, input int seed);
        logic [31:0] c;
        frm.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n - 4; i++) begin
            frm.push_back(8'((i * 37 + seed) & 255));
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) frm.push_back(c[8*k +: 8]);
    endtask

    // Bytes the checker is expected to stream for the frame in frm.
    task automatic add_expected();
        int n;
        n = (frm.size() >= D) ? frm.size() - (D - 1) : 0;
        for (int i = 0; i < n; i++) exp_b.push_back(frm[i]);
    endtask

    task automatic clear_cap();
        rx_b.delete();
        rx_last.delete();
        st_len.delete();
        st_flg.delete();
        exp_b.delete();
    endtask

    function automatic int count_diff();
        int n;
        n = 0;
        for (int i = 0; i < rx_b.size() && i < exp_b.size(); i++)
            if (rx_b[i] !== exp_b[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        rst = 1'b1; cke = 1'b1; en = 1'b0; d = 4'h0; er = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({m_valid, m_data, m_last, stat_valid, stat_len, crc_err, align_err, len_err, phy_err, pre_err} !== 27'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", {m_valid, m_data, m_last, stat_valid, stat_len,
                     crc_err, align_err, len_err, phy_err, pre_err});
        end
        rst = 1'b0;
        clear_cap();
        gap(3);
        total++;
        if (st_len.size() !== 0) begin
            bad++; $display("FAIL reset_idle_stat: got %0d pulses want 0", st_len.size());
        end
    endtask

    task automatic test_good_frame();
        clear_cap(); build_frame(64, 3); add_expected();
        send_pre(15); send_bytes(0, 64, -1); gap(4);
        total++;
        if (rx_b.size() !== exp_b.size()) begin
            bad++; $display("FAIL good_count: got %0d want %0d", rx_b.size(), exp_b.size());
        end
        total++;
        if (count_diff() !== 0) begin
            bad++; $display("FAIL good_data: got %0d wrong bytes want 0", count_diff());
        end
        total++;
        if (rx_last.size() !== 1 || rx_last[0] !== exp_b.size() - 1) begin
            bad++; $display("FAIL good_last: got %0d pulses (first at %0d) want 1 at %0d",
                            rx_last.size(), (rx_last.size() > 0) ? rx_last[0] : -2, exp_b.size() - 1);
        end
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 64 || st_flg[0] !== 5'b00000) begin
            bad++; $display("FAIL good_stat: got %0d pulses len %0d flags %b want 1 pulse len 64 flags 00000",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_flg.size() > 0) ? st_flg[0] : 5'bx);
        end
    endtask

    task automatic test_crc_err();
        clear_cap(); build_frame(64, 3);
        frm[10] = frm[10] ^ 8'h01;
        add_expected();
        send_pre(15); send_bytes(0, 64, -1); gap(4);
        total++;
        if (rx_b.size() !== exp_b.size() || count_diff() !== 0) begin
            bad++; $display("FAIL crc_data: got %0d bytes %0d wrong want %0d bytes 0 wrong",
                            rx_b.size(), count_diff(), exp_b.size());
        end
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 64 || st_flg[0] !== 5'b10000) begin
            bad++; $display("FAIL crc_stat: got %0d pulses len %0d flags %b want 1 pulse len 64 flags 10000",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_flg.size() > 0) ? st_flg[0] : 5'bx);
        end
    endtask

    task automatic test_short_pre();
        clear_cap(); build_frame(64, 5);
        send_pre(7); send_bytes(0, 8, -1);
        total++;
        if (st_len.size() !== 0) begin
            bad++; $display("FAIL pre_early_stat: got %0d pulses want 0 while en high", st_len.size());
        end
        gap(4);
        total++;
        if (rx_b.size() !== 0) begin
            bad++; $display("FAIL pre_no_data: got %0d bytes want 0", rx_b.size());
        end
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 0 || st_flg[0] !== 5'b00001) begin
            bad++; $display("FAIL pre_stat: got %0d pulses len %0d flags %b want 1 pulse len 0 flags 00001",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_flg.size() > 0) ? st_flg[0] : 5'bx);
        end
    endtask

    task automatic test_align();
        clear_cap(); build_frame(64, 11); add_expected();
        send_pre(15); send_bytes(0, 64, -1); nib(1'b1, 4'hA, 1'b0); gap(4);
        total++;
        if (rx_b.size() !== exp_b.size() || count_diff() !== 0) begin
            bad++; $display("FAIL align_data: got %0d bytes %0d wrong want %0d bytes 0 wrong",
                            rx_b.size(), count_diff(), exp_b.size());
        end
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 64 || st_flg[0] !== 5'b01000) begin
            bad++; $display("FAIL align_stat: got %0d pulses len %0d flags %b want 1 pulse len 64 flags 01000",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_flg.size() > 0) ? st_flg[0] : 5'bx);
        end
    endtask

    task automatic test_short_frame();
        clear_cap(); build_frame(20, 7); add_expected();
        send_pre(15); send_bytes(0, 20, -1); gap(4);
        total++;
        if (rx_b.size() !== exp_b.size() || count_diff() !== 0) begin
            bad++; $display("FAIL short_data: got %0d bytes %0d wrong want %0d bytes 0 wrong",
                            rx_b.size(), count_diff(), exp_b.size());
        end
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 20 || st_flg[0] !== 5'b00100) begin
            bad++; $display("FAIL short_stat: got %0d pulses len %0d flags %b want 1 pulse len 20 flags 00100",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_flg.size() > 0) ? st_flg[0] : 5'bx);
        end
    endtask

    task automatic test_phy_err();
        clear_cap(); build_frame(64, 13); add_expected();
        send_pre(15); send_bytes(0, 64, 41); gap(4);
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 64 || st_flg[0] !== 5'b00010) begin
            bad++; $display("FAIL phy_stat: got %0d pulses len %0d flags %b want 1 pulse len 64 flags 00010",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_flg.size() > 0) ? st_flg[0] : 5'bx);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b30;
        clear_cap(); build_frame(64, 9);
        b30 = frm[30];
        send_pre(15); send_bytes(0, 30, -1);
        @(negedge clk);
        rst = 1'b1; en = 1'b1; d = b30[3:0]; er = 1'b0;
        #1 clear_cap();
        @(negedge clk);
        rst = 1'b0; d = b30[7:4];
        total++;
        if ({m_valid, m_data, m_last, stat_valid, stat_len, crc_err, align_err, len_err, phy_err, pre_err} !== 27'd0) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h want 0", {m_valid, m_data, m_last, stat_valid, stat_len,
                     crc_err, align_err, len_err, phy_err, pre_err});
        end
        send_bytes(31, 64, -1);
        total++;
        if (rx_b.size() !== 0 || st_len.size() !== 0) begin
            bad++; $display("FAIL rstmid_quiet: got %0d bytes %0d pulses want 0 and 0", rx_b.size(), st_len.size());
        end
        gap(4);
        total++;
        if (st_len.size() !== 1 || st_len[0] !== 0 || st_flg[0] !== 5'b00001 || rx_b.size() !== 0) begin
            bad++; $display("FAIL rstmid_drop: got %0d pulses len %0d flags %b bytes %0d want 1 pulse len 0 flags 00001 bytes 0",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1,
                            (st_flg.size() > 0) ? st_flg[0] : 5'bx, rx_b.size());
        end
    endtask

    task automatic test_back_to_back();
        int na;
        clear_cap();
        build_frame(64, 1); add_expected(); na = exp_b.size();
        send_pre(15); send_bytes(0, 64, -1);
        gap(1);
        build_frame(70, 2); add_expected();
        send_pre(15); send_bytes(0, 70, -1);
        gap(4);
        total++;
        if (st_len.size() !== 2 || st_len[0] !== 64 || st_len[1] !== 70 || st_flg[0] !== 5'b0 || st_flg[1] !== 5'b0) begin
            bad++; $display("FAIL b2b_stat: got %0d pulses lens %0d/%0d want 2 pulses lens 64/70 flags 0",
                            st_len.size(), (st_len.size() > 0) ? st_len[0] : -1, (st_len.size() > 1) ? st_len[1] : -1);
        end
        total++;
        if (rx_b.size() !== exp_b.size() || count_diff() !== 0) begin
            bad++; $display("FAIL b2b_data: got %0d bytes %0d wrong want %0d bytes 0 wrong",
                            rx_b.size(), count_diff(), exp_b.size());
        end
        total++;
        if (rx_last.size() !== 2 || rx_last[0] !== na - 1 || rx_last[1] !== exp_b.size() - 1) begin
            bad++; $display("FAIL b2b_last: got %0d pulses (first at %0d) want 2 at %0d and %0d",
                            rx_last.size(), (rx_last.size() > 0) ? rx_last[0] : -2, na - 1, exp_b.size() - 1);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_crc_err();
        test_short_pre();
        test_align();
        test_short_frame();
        test_phy_err();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
